// File: rtl/led_trail_fader.sv
// Per-LED afterglow for the light-bar sequencer: each LED jumps to full brightness
// while lit, then fades linearly and drives its pin through a period-aligned PWM.
module led_trail_fader #(
    parameter int unsigned NUM_LEDS      = 10,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned DECAY_STEP    = 8,
    parameter int unsigned DECAY_PERIODS = 3000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] led_in,
    output logic [NUM_LEDS-1:0] LEDR
);

    localparam int unsigned FS     = (1 << PWM_BITS) - 1;
    localparam int unsigned DCNT_W = (DECAY_PERIODS > 1) ? $clog2(DECAY_PERIODS) : 1;

    localparam logic [PWM_BITS-1:0] FULL       = PWM_BITS'(FS);
    localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(DECAY_STEP);
    localparam logic [PWM_BITS-1:0] PWM_LAST   = PWM_BITS'(FS - 1);
    localparam logic [DCNT_W-1:0]   DECAY_LAST = DCNT_W'(DECAY_PERIODS - 1);

    logic [NUM_LEDS-1:0] sync1;
    logic [NUM_LEDS-1:0] led_s;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DCNT_W-1:0]   decay_cnt;
    logic [PWM_BITS-1:0] bright [NUM_LEDS];
    logic [PWM_BITS-1:0] duty   [NUM_LEDS];
    logic                wrap;
    logic                decay_tick;

    // Last PWM cycle of the period, and the wrap that closes a prescaler round.
    always_comb begin
        wrap       = (pwm_cnt == PWM_LAST);
        decay_tick = wrap && (decay_cnt == DECAY_LAST);
    end

    // Two-flop synchronizer for the slow-domain pattern.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= '0;
            led_s <= '0;
        end else begin
            sync1 <= led_in;
            led_s <= sync1;
        end
    end

    // Shared PWM period counter and decay prescaler.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pwm_cnt   <= '0;
            decay_cnt <= '0;
        end else begin
            pwm_cnt <= wrap ? '0 : pwm_cnt + PWM_BITS'(1);
            if (wrap) begin
                decay_cnt <= decay_tick ? '0 : decay_cnt + DCNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        // Load wins over decay; decay saturates at zero.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                bright[i] <= '0;
            end else if (led_s[i]) begin
                bright[i] <= FULL;
            end else if (decay_tick) begin
                bright[i] <= (bright[i] > STEP) ? bright[i] - STEP : '0;
            end
        end

        // Duty only changes at the period boundary so no pulse is ever cut short.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                duty[i] <= '0;
                LEDR[i] <= 1'b0;
            end else begin
                if (wrap) begin
                    duty[i] <= bright[i];
                end
                LEDR[i] <= (pwm_cnt < duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_led_trail_fader.sv
// Directed bench for led_trail_fader with a 3-bit PWM (period 7), step 2, 2 periods per tick.
module tb_led_trail_fader;

    localparam int unsigned NUM_LEDS      = 10;
    localparam int unsigned PWM_BITS      = 3;
    localparam int unsigned DECAY_STEP    = 2;
    localparam int unsigned DECAY_PERIODS = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_LEDS-1:0] led_in;
    logic [NUM_LEDS-1:0] ledr;

    int checks = 0;
    int errs   = 0;

    // Per-period duty of LED0 for the load/decay run (period m spans edges 7m+1..7m+7).
    int unsigned tab_fade [13] = '{0, 7, 7, 7, 7, 5, 5, 3, 3, 1, 1, 0, 0};
    // Per-period duties of LED0..2 for the sweep run.
    int unsigned tab_d0 [13] = '{0, 7, 7, 7, 7, 7, 7, 5, 5, 3, 3, 1, 1};
    int unsigned tab_d1 [13] = '{0, 0, 0, 0, 0, 7, 7, 7, 7, 7, 7, 5, 5};
    int unsigned tab_d2 [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 7};

    always #5 clk = ~clk;

    led_trail_fader #(
        .NUM_LEDS      (NUM_LEDS),
        .PWM_BITS      (PWM_BITS),
        .DECAY_STEP    (DECAY_STEP),
        .DECAY_PERIODS (DECAY_PERIODS)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .led_in   (led_in),
        .LEDR     (ledr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_LEDS-1:0] exp;
        int                  m;
        int                  p;

        // Reset with every input lit.
        reset  = 1'b1;
        led_in = 10'h3FF;
        repeat (3) begin
            tick();
            check_val("rst_ledr", 32'(ledr), 32'h0);
            check_val("rst_pwm", 32'(dut.pwm_cnt), 32'h0);
            check_val("rst_b0", 32'(dut.bright[0]), 32'h0);
            check_val("rst_b9", 32'(dut.bright[9]), 32'h0);
        end

        // Load LED0, hold, then let it fade; edges counted from reset release.
        led_in = 10'h001;
        reset  = 1'b0;
        for (int e = 1; e <= 91; e++) begin
            tick();
            m   = (e - 1) / 7;
            p   = (e - 1) % 7;
            exp = '0;
            exp[0] = (p < int'(tab_fade[m]));
            check_val("fade_ledr", 32'(ledr), 32'(exp));
            if (e == 2)  check_val("load_lat2", 32'(dut.bright[0]), 32'd0);
            if (e == 3)  check_val("load_lat3", 32'(dut.bright[0]), 32'd7);
            if (e == 27) check_val("fade_b27", 32'(dut.bright[0]), 32'd7);
            if (e == 28) check_val("fade_b28", 32'(dut.bright[0]), 32'd5);
            if (e == 42) check_val("fade_b42", 32'(dut.bright[0]), 32'd3);
            if (e == 56) check_val("fade_b56", 32'(dut.bright[0]), 32'd1);
            if (e == 70) check_val("fade_b70", 32'(dut.bright[0]), 32'd0);
            if (e == 84) check_val("fade_b84", 32'(dut.bright[0]), 32'd0);
            if (e == 21) led_in = 10'h000;
        end

        // One-sample pulse timed so the load lands on the decay tick at edge 98.
        for (int e = 92; e <= 112; e++) begin
            tick();
            if (e == 97)  check_val("race_b97", 32'(dut.bright[0]), 32'd0);
            if (e == 98)  check_val("race_b98", 32'(dut.bright[0]), 32'd7);
            if (e == 111) check_val("race_b111", 32'(dut.bright[0]), 32'd7);
            if (e == 112) check_val("race_b112", 32'(dut.bright[0]), 32'd5);
            if (e == 95) led_in = 10'h001;
            if (e == 96) led_in = 10'h000;
        end

        // Sweep 0x001 -> 0x002 -> 0x004, 30 cycles each, checking every output cycle.
        reset = 1'b1;
        repeat (2) tick();
        led_in = 10'h001;
        reset  = 1'b0;
        for (int e = 1; e <= 91; e++) begin
            tick();
            m   = (e - 1) / 7;
            p   = (e - 1) % 7;
            exp = '0;
            exp[0] = (p < int'(tab_d0[m]));
            exp[1] = (p < int'(tab_d1[m]));
            exp[2] = (p < int'(tab_d2[m]));
            check_val("sweep_ledr", 32'(ledr), 32'(exp));
            if (e == 30) led_in = 10'h002;
            if (e == 60) led_in = 10'h004;
        end

        // Reset in the middle of LED3's fade.
        reset = 1'b1;
        repeat (2) tick();
        led_in = 10'h008;
        reset  = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 4) led_in = 10'h000;
        end
        check_val("mid_b3", 32'(dut.bright[3]), 32'd5);
        reset = 1'b1;
        tick();
        check_val("mid_rst_b3", 32'(dut.bright[3]), 32'd0);
        check_val("mid_rst_ledr", 32'(ledr), 32'h0);
        check_val("mid_rst_pwm", 32'(dut.pwm_cnt), 32'h0);
        led_in = 10'h008;
        tick();
        reset = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 3) check_val("resume_b3", 32'(dut.bright[3]), 32'd7);
            check_val("resume_ledr", 32'(ledr), (e >= 8) ? 32'h008 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
